// File: rtl/pipe_mux_n_if.sv
// -----------------------------------------------------------------------------
// pipe_mux_n_if : select/handshake bundle for pipe_mux_n
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface pipe_mux_n_if #(
  parameter int SIZE   = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) ();
  logic [NUM_IN*SIZE-1:0] data_i;
  logic [SEL_W-1:0]       select_i;
  logic                   valid_i;
  logic                   stall_i;
  logic                   flush_i;
  logic [SIZE-1:0]        data_o;
  logic                   valid_o;
  logic                   sel_err_o;
  logic [7:0]             err_cnt_o;

  modport master (
    output data_i, select_i, valid_i, stall_i, flush_i,
    input  data_o, valid_o, sel_err_o, err_cnt_o
  );

  modport slave (
    input  data_i, select_i, valid_i, stall_i, flush_i,
    output data_o, valid_o, sel_err_o, err_cnt_o
  );
endinterface

`default_nettype wire

// File: rtl/pipe_mux_n.sv
// -----------------------------------------------------------------------------
// pipe_mux_n : NUM_IN-way word select, STAGES-deep pipeline with stall/flush.
// Optional saturating error counter enabled by PIPE_MUX_ERRCNT_EN.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module pipe_mux_n #(
  parameter int SIZE   = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2,
  parameter int STAGES = 1
) (
  input  wire logic     clk_i,
  input  wire logic     rst_i,
  pipe_mux_n_if.slave   bus_if
);

  logic [SIZE-1:0]   data_q [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] err_q;
  logic [SIZE-1:0]   last_good_q;
  logic [SIZE-1:0]   last_good_d;
  logic [SIZE-1:0]   pick;
  logic              in_range;
  logic              shift;

  // Out-of-range selects fall through to last_good, so no latch is possible.
  always_comb begin
    pick     = last_good_q;
    in_range = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus_if.select_i == SEL_W'(k)) begin
        pick     = bus_if.data_i[k*SIZE +: SIZE];
        in_range = 1'b1;
      end
    end
  end

  assign shift = ~bus_if.flush_i & ~bus_if.stall_i;

  always_comb begin
    last_good_d = last_good_q;
    if (shift && bus_if.valid_i && in_range) begin
      last_good_d = pick;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_good_q <= '0;
    end else begin
      last_good_q <= last_good_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || bus_if.flush_i) begin
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= '0;
      err_q   <= '0;
    end else if (!bus_if.stall_i) begin
      data_q[0]  <= pick;
      valid_q[0] <= bus_if.valid_i;
      err_q[0]   <= ~in_range & bus_if.valid_i;
      for (int i = 1; i < STAGES; i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
      end
    end
  end

  assign bus_if.data_o    = data_q[STAGES-1];
  assign bus_if.valid_o   = valid_q[STAGES-1];
  assign bus_if.sel_err_o = err_q[STAGES-1];

`ifdef PIPE_MUX_ERRCNT_EN
  logic [7:0] err_cnt_q;
  logic [7:0] err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (shift && bus_if.valid_i && !in_range && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus_if.err_cnt_o = err_cnt_q;
`else
  assign bus_if.err_cnt_o = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_mux_n.sv
// -----------------------------------------------------------------------------
// tb_pipe_mux_n : directed bench driving STAGES=1/2/3 instances in parallel
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_pipe_mux_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] data;
  logic [1:0]  sel;
  logic        vld;
  logic        stl;
  logic        fls;
  int          total = 0;
  int          bad   = 0;

`ifdef PIPE_MUX_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  always #5 clk = ~clk;

  pipe_mux_n_if #(.SIZE(32), .NUM_IN(3), .SEL_W(2)) if1 ();
  pipe_mux_n_if #(.SIZE(32), .NUM_IN(3), .SEL_W(2)) if2 ();
  pipe_mux_n_if #(.SIZE(32), .NUM_IN(3), .SEL_W(2)) if3 ();

  assign if1.data_i = data;  assign if1.select_i = sel;  assign if1.valid_i = vld;
  assign if1.stall_i = stl;  assign if1.flush_i = fls;
  assign if2.data_i = data;  assign if2.select_i = sel;  assign if2.valid_i = vld;
  assign if2.stall_i = stl;  assign if2.flush_i = fls;
  assign if3.data_i = data;  assign if3.select_i = sel;  assign if3.valid_i = vld;
  assign if3.stall_i = stl;  assign if3.flush_i = fls;

  pipe_mux_n #(.SIZE(32), .NUM_IN(3), .SEL_W(2), .STAGES(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .bus_if(if1.slave));
  pipe_mux_n #(.SIZE(32), .NUM_IN(3), .SEL_W(2), .STAGES(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .bus_if(if2.slave));
  pipe_mux_n #(.SIZE(32), .NUM_IN(3), .SEL_W(2), .STAGES(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .bus_if(if3.slave));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic st, input logic fl);
    vld = v; sel = s; stl = st; fls = fl;
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    return ERRCNT ? 32'(n) : 32'd0;
  endfunction

  initial begin
    rst  = 1'b1;
    data = {32'h33, 32'h22, 32'h11};
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    step(); step();
    check_eq("rst_d1_data",  if1.data_o, 32'h0);
    check_eq("rst_d1_valid", 32'(if1.valid_o), 32'h0);
    check_eq("rst_d1_err",   32'(if1.sel_err_o), 32'h0);
    check_eq("rst_d1_cnt",   32'(if1.err_cnt_o), 32'h0);
    check_eq("rst_d3_valid", 32'(if3.valid_o), 32'h0);
    rst = 1'b0;

    // basic select and out-of-range re-issue
    drive(1'b1, 2'd1, 1'b0, 1'b0); step();
    check_eq("sel1_data",  if1.data_o, 32'h22);
    check_eq("sel1_valid", 32'(if1.valid_o), 32'h1);
    check_eq("sel1_err",   32'(if1.sel_err_o), 32'h0);
    drive(1'b1, 2'd2, 1'b0, 1'b0); step();
    check_eq("sel2_data",  if1.data_o, 32'h33);
    drive(1'b1, 2'd3, 1'b0, 1'b0); step();
    check_eq("oor_data",   if1.data_o, 32'h33);
    check_eq("oor_err",    32'(if1.sel_err_o), 32'h1);
    check_eq("oor_cnt",    32'(if1.err_cnt_o), exp_cnt(1));
    check_eq("d3_lat_first", if3.data_o, 32'h22);
    drive(1'b0, 2'd0, 1'b0, 1'b0); step();
    check_eq("bubble_valid", 32'(if1.valid_o), 32'h0);
    check_eq("bubble_pick",  if1.data_o, 32'h11);
    check_eq("d3_second",    if3.data_o, 32'h33);
    step();
    check_eq("d3_third_err", 32'(if3.sel_err_o), 32'h1);
    step();
    check_eq("d3_bubble",    32'(if3.valid_o), 32'h0);

    // latency on the 3-deep instance: selects 0,1,2 back to back
    drive(1'b1, 2'd0, 1'b0, 1'b0); step();
    drive(1'b1, 2'd1, 1'b0, 1'b0); step();
    check_eq("lat_not_yet", 32'(if3.valid_o), 32'h0);
    drive(1'b1, 2'd2, 1'b0, 1'b0); step();
    check_eq("lat_w0", if3.data_o, 32'h11);
    check_eq("lat_v0", 32'(if3.valid_o), 32'h1);
    drive(1'b0, 2'd0, 1'b0, 1'b0); step();
    check_eq("lat_w1", if3.data_o, 32'h22);
    step();
    check_eq("lat_w2", if3.data_o, 32'h33);
    check_eq("lat_v2", 32'(if3.valid_o), 32'h1);
    step();
    check_eq("lat_end", 32'(if3.valid_o), 32'h0);

    // stall on the 2-deep instance
    drive(1'b1, 2'd0, 1'b0, 1'b0); step();
    drive(1'b1, 2'd1, 1'b0, 1'b0); step();
    check_eq("stl_pre", if2.data_o, 32'h11);
    for (int n = 0; n < 2; n++) begin
      drive(1'b1, 2'd2, 1'b1, 1'b0); step();
      check_eq("stl_hold_data",  if2.data_o, 32'h11);
      check_eq("stl_hold_valid", 32'(if2.valid_o), 32'h1);
    end
    drive(1'b1, 2'd2, 1'b0, 1'b0); step();
    check_eq("stl_rel_w1", if2.data_o, 32'h22);
    drive(1'b0, 2'd0, 1'b0, 1'b0); step();
    check_eq("stl_rel_w2", if2.data_o, 32'h33);
    step();
    check_eq("stl_rel_end", 32'(if2.valid_o), 32'h0);

    // flush beats stall; last_good (0x22) survives the flush
    drive(1'b1, 2'd0, 1'b0, 1'b0); step();
    drive(1'b1, 2'd1, 1'b0, 1'b0); step();
    check_eq("fl_pre", if2.data_o, 32'h11);
    drive(1'b1, 2'd2, 1'b1, 1'b1); step();
    check_eq("fl_d2_valid", 32'(if2.valid_o), 32'h0);
    check_eq("fl_d2_data",  if2.data_o, 32'h0);
    check_eq("fl_d1_data",  if1.data_o, 32'h0);
    drive(1'b1, 2'd3, 1'b0, 1'b0); step();
    check_eq("fl_lastgood", if1.data_o, 32'h22);
    check_eq("fl_oor_err",  32'(if1.sel_err_o), 32'h1);
    check_eq("fl_cnt",      32'(if1.err_cnt_o), exp_cnt(2));

    // saturation then reset
    for (int n = 0; n < 300; n++) step();
    check_eq("sat_cnt",  32'(if1.err_cnt_o), exp_cnt(255));
    check_eq("sat_data", if1.data_o, 32'h22);
    rst = 1'b1; step();
    rst = 1'b0; drive(1'b0, 2'd0, 1'b0, 1'b0);
    check_eq("rst2_d1_data",  if1.data_o, 32'h0);
    check_eq("rst2_d1_valid", 32'(if1.valid_o), 32'h0);
    check_eq("rst2_d1_err",   32'(if1.sel_err_o), 32'h0);
    check_eq("rst2_d1_cnt",   32'(if1.err_cnt_o), 32'h0);
    check_eq("rst2_d3_valid", 32'(if3.valid_o), 32'h0);
    check_eq("rst2_d2_data",  if2.data_o, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
